// File: rtl/matmul_pkg.sv
// Shared definitions for the tiled matmul output path: default widths,
// controller state encoding and a constant-expression log2 helper.
package matmul_pkg;

   localparam int DEF_DWIDTH  = 16;
   localparam int DEF_BB_SIZE = 16;
   localparam int DEF_AWIDTH  = 7;
   localparam int ROW_W       = DEF_BB_SIZE * DEF_DWIDTH;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      FULL,
      DRAIN
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/c_bank_ram.sv
// One C-row bank: 2^AWIDTH rows of one building-block row each, 1-cycle read.
module c_bank_ram
   import matmul_pkg::*;
#(
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int WIDTH  = ROW_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   single_port_ram #(
      .AWIDTH (AWIDTH),
      .WIDTH  (WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (i_we),
      .i_re    (i_re),
      .i_addr  (i_addr),
      .i_wdata (i_wdata),
      .o_rdata (o_rdata)
   );

endmodule

// File: rtl/single_port_ram.sv
// Generic single-port RAM: synchronous write, registered read port.
module single_port_ram #(
   parameter int AWIDTH = 7,
   parameter int WIDTH  = 256
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [2**AWIDTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/tiled_c_bank_ctrl.sv
// Captures one C row per tile-row into GRID banks, then drains the selected
// banks in order over a valid/ready stream through a 2-entry output FIFO.
module tiled_c_bank_ctrl
   import matmul_pkg::*;
#(
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int BB_SIZE  = DEF_BB_SIZE,
   parameter int GRID     = 2,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int NUM_ROWS = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              c_valid_in,
   input  logic [GRID*BB_SIZE*DWIDTH-1:0]    c_data_in,
   input  logic                              drain_start,
   input  logic [GRID-1:0]                   bank_mask,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [BB_SIZE*DWIDTH-1:0]         out_data,
   output logic [((GRID > 1) ? clog2(GRID) : 1)-1:0] out_bank,
   output logic [AWIDTH-1:0]                 out_row,
   output logic                              out_last,
   output logic                              full,
   output logic                              drain_done,
   output logic                              overflow_err
);

   localparam int BW = (GRID > 1) ? clog2(GRID) : 1;
   localparam int RW = BB_SIZE * DWIDTH;
   localparam logic [AWIDTH-1:0] LAST_ROW = AWIDTH'(NUM_ROWS - 1);

   typedef struct packed {
      logic [RW-1:0]     data;
      logic [BW-1:0]     bank;
      logic [AWIDTH-1:0] row;
      logic              last;
   } beat_t;

   // Returns {found, index} of the lowest set mask bit at or above start.
   function automatic logic [BW:0] findFrom(input logic [GRID-1:0] m, input int start);
      logic [BW:0] res;
      res = '0;
      for (int i = GRID - 1; i >= 0; i--) begin
         if (i >= start && m[i]) res = {1'b1, BW'(i)};
      end
      return res;
   endfunction

   state_t            r_state;
   logic [AWIDTH-1:0] r_wrRow;
   logic [AWIDTH-1:0] r_rdRow;
   logic [BW-1:0]     r_rdBank;
   logic [GRID-1:0]   r_mask;
   logic              r_rdActive;
   logic              r_inFlight;
   logic [BW-1:0]     r_ifBank;
   logic [AWIDTH-1:0] r_ifRow;
   logic              r_ifLast;
   logic              r_full;
   logic              r_drainDone;
   logic              r_overflow;
   beat_t             r_fifo [2];
   logic              r_fifoWr;
   logic              r_fifoRd;
   logic [1:0]        r_count;

   logic              w_capture;
   logic              w_startDrain;
   logic [BW:0]       w_first;
   logic [BW:0]       w_next;
   logic [GRID-1:0]   w_mask;
   logic [BW-1:0]     w_curBank;
   logic [AWIDTH-1:0] w_curRow;
   logic              w_pop;
   logic [2:0]        w_occ;
   logic              w_issue;
   logic              w_rowEnd;
   logic              w_issueLast;
   logic [AWIDTH-1:0] w_addr;
   beat_t             w_head;
   logic [RW-1:0]     w_ramData [GRID];

   assign w_capture    = c_valid_in && (r_state == IDLE || r_state == CAPTURE);
   assign w_first      = findFrom(bank_mask, 0);
   assign w_startDrain = (r_state == FULL) && drain_start && w_first[BW];
   assign w_mask       = w_startDrain ? bank_mask : r_mask;
   assign w_curBank    = w_startDrain ? w_first[BW-1:0] : r_rdBank;
   assign w_curRow     = w_startDrain ? '0 : r_rdRow;
   assign w_next       = findFrom(w_mask, int'(w_curBank) + 1);
   assign w_rowEnd     = (w_curRow == LAST_ROW);
   assign w_issueLast  = w_rowEnd && !w_next[BW];
   assign w_pop        = (r_count != 2'd0) && out_ready;
   // Occupancy counted after this cycle's pop so a steady stream sustains 1 beat/cycle.
   assign w_occ        = {1'b0, r_count} - {2'b0, w_pop} + {2'b0, r_inFlight};
   assign w_issue      = w_startDrain || (r_state == DRAIN && r_rdActive && w_occ < 3'd2);
   assign w_addr       = w_capture ? r_wrRow : w_curRow;
   assign w_head       = r_fifo[r_fifoRd];

   for (genvar g = 0; g < GRID; g++) begin : g_bank
      c_bank_ram #(
         .AWIDTH (AWIDTH),
         .WIDTH  (RW)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_capture),
         .i_re    (w_issue && (w_curBank == BW'(g))),
         .i_addr  (w_addr),
         .i_wdata (c_data_in[g*RW +: RW]),
         .o_rdata (w_ramData[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_wrRow     <= '0;
         r_rdRow     <= '0;
         r_rdBank    <= '0;
         r_mask      <= '0;
         r_rdActive  <= 1'b0;
         r_inFlight  <= 1'b0;
         r_ifBank    <= '0;
         r_ifRow     <= '0;
         r_ifLast    <= 1'b0;
         r_full      <= 1'b0;
         r_drainDone <= 1'b0;
         r_overflow  <= 1'b0;
         r_fifo[0]   <= '0;
         r_fifo[1]   <= '0;
         r_fifoWr    <= 1'b0;
         r_fifoRd    <= 1'b0;
         r_count     <= '0;
      end else begin
         r_drainDone <= 1'b0;
         if (c_valid_in && (r_state == FULL || r_state == DRAIN)) r_overflow <= 1'b1;

         if (r_inFlight) begin
            r_fifo[r_fifoWr] <= '{data: w_ramData[r_ifBank], bank: r_ifBank,
                                  row: r_ifRow, last: r_ifLast};
            r_fifoWr <= ~r_fifoWr;
         end
         if (w_pop) r_fifoRd <= ~r_fifoRd;
         r_count    <= r_count + {1'b0, r_inFlight} - {1'b0, w_pop};
         r_inFlight <= w_issue;

         if (w_issue) begin
            r_ifBank <= w_curBank;
            r_ifRow  <= w_curRow;
            r_ifLast <= w_issueLast;
            if (w_rowEnd) begin
               r_rdRow    <= '0;
               r_rdBank   <= w_next[BW-1:0];
               r_rdActive <= w_next[BW];
            end else begin
               r_rdRow    <= w_curRow + AWIDTH'(1);
               r_rdBank   <= w_curBank;
               r_rdActive <= 1'b1;
            end
         end

         case (r_state)
            IDLE, CAPTURE: begin
               if (c_valid_in) begin
                  if (r_wrRow == LAST_ROW) begin
                     r_wrRow <= '0;
                     r_full  <= 1'b1;
                     r_state <= FULL;
                  end else begin
                     r_wrRow <= r_wrRow + AWIDTH'(1);
                     r_state <= CAPTURE;
                  end
               end
            end
            FULL: begin
               if (drain_start) begin
                  r_full <= 1'b0;
                  if (w_first[BW]) begin
                     r_mask  <= bank_mask;
                     r_state <= DRAIN;
                  end else begin
                     r_state     <= IDLE;
                     r_drainDone <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_pop && w_head.last) begin
                  r_state     <= IDLE;
                  r_drainDone <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid    = (r_count != 2'd0);
   assign out_data     = w_head.data;
   assign out_bank     = w_head.bank;
   assign out_row      = w_head.row;
   assign out_last     = out_valid && w_head.last;
   assign full         = r_full;
   assign drain_done   = r_drainDone;
   assign overflow_err = r_overflow;

endmodule

// File: tb/tb_tiled_c_bank_ctrl.sv
// Self-checking bench for tiled_c_bank_ctrl: a GRID=2/16-row instance for the
// main scenarios and a GRID=4/1-row instance for the sparse-mask corner.
module tb_tiled_c_bank_ctrl;

   localparam int RW = 256;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic            cValid;
   logic [2*RW-1:0] cData;
   logic            drainStart;
   logic [1:0]      bankMask;
   logic            outReady;
   logic            outValid;
   logic [RW-1:0]   outData;
   logic [0:0]      outBank;
   logic [6:0]      outRow;
   logic            outLast, full, drainDone, overflowErr;

   logic            c4Valid;
   logic [4*RW-1:0] c4Data;
   logic            d4Start;
   logic [3:0]      mask4;
   logic            out4Ready;
   logic            out4Valid;
   logic [RW-1:0]   out4Data;
   logic [1:0]      out4Bank;
   logic [6:0]      out4Row;
   logic            out4Last, full4, done4, ovf4;

   int vectors = 0;
   int miscompares = 0;

   // Reference contents of every bank row, updated whenever a row is written.
   logic [RW-1:0] model2 [2][16];
   logic [RW-1:0] model4 [4];

   // Free-running 100 MHz clock shared by both instances.
   always #5 clk = ~clk;

   tiled_c_bank_ctrl #(
      .DWIDTH(16), .BB_SIZE(16), .GRID(2), .AWIDTH(7), .NUM_ROWS(16)
   ) dut (
      .clk(clk), .reset(reset), .c_valid_in(cValid), .c_data_in(cData),
      .drain_start(drainStart), .bank_mask(bankMask), .out_valid(outValid),
      .out_ready(outReady), .out_data(outData), .out_bank(outBank),
      .out_row(outRow), .out_last(outLast), .full(full),
      .drain_done(drainDone), .overflow_err(overflowErr)
   );

   tiled_c_bank_ctrl #(
      .DWIDTH(16), .BB_SIZE(16), .GRID(4), .AWIDTH(7), .NUM_ROWS(1)
   ) dut4 (
      .clk(clk), .reset(reset), .c_valid_in(c4Valid), .c_data_in(c4Data),
      .drain_start(d4Start), .bank_mask(mask4), .out_valid(out4Valid),
      .out_ready(out4Ready), .out_data(out4Data), .out_bank(out4Bank),
      .out_row(out4Row), .out_last(out4Last), .full(full4),
      .drain_done(done4), .overflow_err(ovf4)
   );

   function automatic logic [RW-1:0] randRow();
      logic [RW-1:0] v;
      for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reset values on both instances, then drain_start while IDLE must be ignored.
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({outValid, outLast, full, drainDone, overflowErr} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b want 00000", {outValid, outLast, full, drainDone, overflowErr});
      end
      vectors++;
      if (outData !== '0 || outBank !== 1'b0 || outRow !== 7'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_beat: got data=%h bank=%0d row=%0d want 0", outData, outBank, outRow);
      end
      vectors++;
      if ({out4Valid, out4Last, full4, done4, ovf4} !== 5'b0 || out4Bank !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_grid4: got %b bank=%0d want 0", {out4Valid, out4Last, full4, done4, ovf4}, out4Bank);
      end
      reset = 1'b0;
      drainStart = 1'b1;
      bankMask = 2'b11;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drainStart = 1'b0;
         vectors++;
         if ({outValid, drainDone, full} !== 3'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_drain_ignored: got valid/done/full=%b want 000", {outValid, drainDone, full});
         end
      end
   endtask

   // Writes 16 rows into both banks; full must rise only after the 16th row.
   task automatic fillBanks(input bit randomData);
      logic [RW-1:0] row;
      for (int r = 0; r < 16; r++) begin
         @(negedge clk);
         vectors++;
         if (full !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_full_early: row %0d got full=%b want 0", r, full);
         end
         cValid = 1'b1;
         for (int g = 0; g < 2; g++) begin
            row = randomData ? randRow() : {16{16'(g * 256 + r)}};
            cData[g*RW +: RW] = row;
            model2[g][r] = row;
         end
      end
      @(negedge clk);
      cValid = 1'b0;
      vectors++;
      if (full !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL fill_full: got full=%b want 1", full);
      end
   endtask

   // Drains with the given mask; readyMode 0=always, 1=pattern 1,0,0,1, 2=random.
   task automatic test_drain(input logic [1:0] mask, input int readyMode, input int abortAfter);
      int qBank[$];
      int qRow[$];
      int expTotal, accepted, cyc;
      bit holding, done;
      logic [RW-1:0] hData;
      logic [0:0]    hBank;
      logic [6:0]    hRow;
      logic          hLast;
      for (int g = 0; g < 2; g++)
         if (mask[g])
            for (int r = 0; r < 16; r++) begin
               qBank.push_back(g);
               qRow.push_back(r);
            end
      expTotal = qBank.size();
      accepted = 0;
      holding = 1'b0;
      done = 1'b0;
      hData = '0; hBank = '0; hRow = '0; hLast = 1'b0;
      @(negedge clk);
      drainStart = 1'b1;
      bankMask = mask;
      outReady = 1'b0;
      for (cyc = 1; cyc <= 400 && !done; cyc++) begin
         @(negedge clk);
         drainStart = 1'b0;
         if (cyc == 1) begin
            vectors++;
            if (outValid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL drain_latency_early: got out_valid=%b want 0", outValid);
            end
         end
         if (cyc == 2) begin
            vectors++;
            if (outValid !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL drain_latency: got out_valid=%b want 1", outValid);
            end
         end
         if (holding) begin
            vectors++;
            if (outValid !== 1'b1 || outData !== hData || outBank !== hBank || outRow !== hRow || outLast !== hLast) begin
               miscompares++;
               $display("[TB] FAIL stall_hold: got v=%b bank=%0d row=%0d want v=1 bank=%0d row=%0d", outValid, outBank, outRow, hBank, hRow);
            end
         end else if (readyMode == 0 && cyc >= 2) begin
            vectors++;
            if (outValid !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL throughput: cycle %0d got out_valid=%b want 1", cyc, outValid);
            end
         end
         case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = (((cyc - 2) % 4) == 0) || (((cyc - 2) % 4) == 3);
            default: outReady = 1'($urandom_range(0, 1));
         endcase
         if (outValid === 1'b1 && outReady) begin
            vectors++;
            if (qBank.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL extra_beat: got bank=%0d row=%0d want none", outBank, outRow);
               done = 1'b1;
            end else begin
               if (outData !== model2[qBank[0]][qRow[0]] || outBank !== 1'(qBank[0]) ||
                   outRow !== 7'(qRow[0]) || outLast !== (qBank.size() == 1)) begin
                  miscompares++;
                  $display("[TB] FAIL beat: got bank=%0d row=%0d last=%b data=%h want bank=%0d row=%0d last=%b data=%h",
                           outBank, outRow, outLast, outData[31:0], qBank[0], qRow[0], qBank.size() == 1,
                           model2[qBank[0]][qRow[0]][31:0]);
               end
               void'(qBank.pop_front());
               void'(qRow.pop_front());
               accepted++;
               if (abortAfter != 0 && accepted == abortAfter) return;
               if (qBank.size() == 0) done = 1'b1;
            end
         end
         holding = (outValid === 1'b1) && !outReady;
         if (holding) begin
            hData = outData; hBank = outBank; hRow = outRow; hLast = outLast;
         end
      end
      vectors++;
      if (!done || accepted != expTotal) begin
         miscompares++;
         $display("[TB] FAIL drain_count: got %0d beats want %0d", accepted, expTotal);
      end
      @(negedge clk);
      vectors++;
      if (drainDone !== 1'b1 || outValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL drain_done: got done=%b valid=%b want done=1 valid=0", drainDone, outValid);
      end
      @(negedge clk);
      outReady = 1'b0;
      vectors++;
      if (drainDone !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL drain_done_pulse: got %b want 0", drainDone);
      end
   endtask

   // Writes while FULL must flag overflow and leave bank contents untouched.
   task automatic test_overflow();
      fillBanks(1'b1);
      @(negedge clk);
      cValid = 1'b1;
      cData = '1;
      @(negedge clk);
      @(negedge clk);
      cValid = 1'b0;
      vectors++;
      if (overflowErr !== 1'b1 || full !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overflow_set: got err=%b full=%b want 1 1", overflowErr, full);
      end
      test_drain(2'b11, 2, 0);
      vectors++;
      if (overflowErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overflow_sticky: got %b want 1", overflowErr);
      end
   endtask

   // Empty mask: no beats, immediate drain_done, back to IDLE.
   task automatic test_mask_zero();
      fillBanks(1'b1);
      @(negedge clk);
      drainStart = 1'b1;
      bankMask = 2'b00;
      @(negedge clk);
      drainStart = 1'b0;
      vectors++;
      if (drainDone !== 1'b1 || full !== 1'b0 || outValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mask_zero: got done=%b full=%b valid=%b want 1 0 0", drainDone, full, outValid);
      end
      @(negedge clk);
      vectors++;
      if (drainDone !== 1'b0 || outValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mask_zero_after: got done=%b valid=%b want 0 0", drainDone, outValid);
      end
   endtask

   // Reset after 7 beats discards the drain; a fresh fill and drain must work.
   task automatic test_reset_mid_drain();
      fillBanks(1'b1);
      test_drain(2'b11, 0, 7);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({outValid, full, drainDone, overflowErr} !== 4'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: got valid/full/done/err=%b want 0000", {outValid, full, drainDone, overflowErr});
      end
      reset = 1'b0;
      outReady = 1'b0;
      fillBanks(1'b1);
      test_drain(2'b11, 0, 0);
   endtask

   // Single-row, four-bank instance with a sparse mask.
   task automatic test_grid4();
      int expG[2];
      int got;
      logic [RW-1:0] row;
      expG[0] = 0;
      expG[1] = 2;
      got = 0;
      @(negedge clk);
      c4Valid = 1'b1;
      for (int g = 0; g < 4; g++) begin
         row = randRow();
         c4Data[g*RW +: RW] = row;
         model4[g] = row;
      end
      @(negedge clk);
      c4Valid = 1'b0;
      vectors++;
      if (full4 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL grid4_full: got %b want 1", full4);
      end
      d4Start = 1'b1;
      mask4 = 4'b0101;
      out4Ready = 1'b1;
      for (int c = 0; c < 20 && got < 2; c++) begin
         @(negedge clk);
         d4Start = 1'b0;
         if (out4Valid === 1'b1) begin
            vectors++;
            if (out4Data !== model4[expG[got]] || out4Bank !== 2'(expG[got]) ||
                out4Row !== 7'd0 || out4Last !== (got == 1)) begin
               miscompares++;
               $display("[TB] FAIL grid4_beat: got bank=%0d row=%0d last=%b want bank=%0d row=0 last=%b",
                        out4Bank, out4Row, out4Last, expG[got], got == 1);
            end
            got++;
         end
      end
      vectors++;
      if (got != 2) begin
         miscompares++;
         $display("[TB] FAIL grid4_count: got %0d beats want 2", got);
      end
      @(negedge clk);
      vectors++;
      if (done4 !== 1'b1 || out4Valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL grid4_done: got done=%b valid=%b want 1 0", done4, out4Valid);
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      cValid = 1'b0; cData = '0; drainStart = 1'b0; bankMask = '0; outReady = 1'b0;
      c4Valid = 1'b0; c4Data = '0; d4Start = 1'b0; mask4 = '0; out4Ready = 1'b0;
      test_reset();
      fillBanks(1'b0);
      test_drain(2'b11, 0, 0);
      fillBanks(1'b0);
      test_drain(2'b10, 1, 0);
      test_overflow();
      test_mask_zero();
      test_reset_mid_drain();
      test_grid4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop in case a scenario never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
